// File: rtl/pfr_rst_gate_pkg.sv
// ============================================================================
// Module      : pfr_rst_gate_pkg
// Description : Shared types and constants for the PFR main reset gate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pfr_rst_gate_pkg;

    typedef enum logic [1:0] {
        HELD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } rst_chan_state_e;

    // Consecutive equal samples needed before a filtered input may change.
    localparam int RST_FILT_LEN = 4;

endpackage : pfr_rst_gate_pkg

`default_nettype wire

// File: rtl/pfr_rst_chan.sv
// ============================================================================
// Module      : pfr_rst_chan
// Description : One reset-release channel: HELD/WAIT/RUN FSM with minimum
//               assertion counter and request-drop pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfr_rst_chan
    import pfr_rst_gate_pkg::*;
#(
    parameter int MIN_ASSERT_CYCLES = 5000,
    parameter int CNT_W             = 16
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            req_i,
    input  logic            release_en_i,
    output rst_chan_state_e state_o,
    output logic            rst_n_o,
    output logic            req_drop_o
);

    localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_ASSERT_CYCLES);

    rst_chan_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_d, drop_q, rst_n_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        case (state_q)
            HELD: begin
                if (cnt_q == C_MIN) state_d = WAIT;
                else                cnt_d   = cnt_q + CNT_W'(1);
            end
            WAIT: begin
                if (req_i && release_en_i) state_d = RUN;
            end
            RUN: begin
                // A request drop wins over a simultaneous PFR hold.
                if (!req_i) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    drop_d  = 1'b1;
                end else if (!release_en_i) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = HELD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= HELD;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            rst_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            rst_n_q <= (state_d == RUN);
        end
    end

    assign state_o    = state_q;
    assign rst_n_o    = rst_n_q;
    assign req_drop_o = drop_q;

endmodule : pfr_rst_chan

`default_nettype wire

// File: rtl/pfr_main_rst_gate.sv
// ============================================================================
// Module      : pfr_main_rst_gate
// Description : Gates main-CPLD reset releases and PWROKs with PFR permission.
//               Optional input glitch filter: PFR_RST_REQ_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfr_main_rst_gate
    import pfr_rst_gate_pkg::*;
#(
    parameter int MIN_ASSERT_CYCLES = 5000,
    parameter int CNT_W             = 16,
    parameter int SYNC_STAGES       = 2
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       rsmrst_req_n,
    input  logic       srst_bmc_req_n,
    input  logic       pch_pwrok_in,
    input  logic       sys_pwrok_in,
    input  logic       pch_release_en,
    input  logic       bmc_release_en,
    output logic       rst_rsmrst_n,
    output logic       rst_srst_bmc_n,
    output logic       pch_pwrok_out,
    output logic       sys_pwrok_out,
    output logic       pch_req_drop,
    output logic       bmc_req_drop,
    output logic [3:0] status
);

    localparam int C_NIN = 4;

    // Bit order: 0 PCH request, 1 BMC request, 2 PCH PWROK, 3 SYS PWROK.
    logic [C_NIN-1:0]       async_w;
    logic [SYNC_STAGES-1:0] sync_q [C_NIN];
    logic [C_NIN-1:0]       sync_w, clean_w;

    assign async_w = {sys_pwrok_in, pch_pwrok_in, srst_bmc_req_n, rsmrst_req_n};

    always_ff @(posedge clk) begin
        for (int i = 0; i < C_NIN; i++) begin
            if (srst) sync_q[i] <= '0;
            else      sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_w[i]};
        end
    end

    for (genvar g = 0; g < C_NIN; g++) begin : g_tap
        assign sync_w[g] = sync_q[g][SYNC_STAGES-1];
    end

`ifdef PFR_RST_REQ_GLITCH_FILTER_EN
    localparam int C_FW = $clog2(RST_FILT_LEN);

    logic [C_NIN-1:0] filt_q;
    logic [C_FW-1:0]  fcnt_q [C_NIN];

    always_ff @(posedge clk) begin
        for (int i = 0; i < C_NIN; i++) begin
            if (srst) begin
                filt_q[i] <= 1'b0;
                fcnt_q[i] <= '0;
            end else if (sync_w[i] == filt_q[i]) begin
                fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == C_FW'(RST_FILT_LEN - 1)) begin
                filt_q[i] <= sync_w[i];
                fcnt_q[i] <= '0;
            end else begin
                fcnt_q[i] <= fcnt_q[i] + C_FW'(1);
            end
        end
    end

    assign clean_w = filt_q;
`else
    assign clean_w = sync_w;
`endif

    rst_chan_state_e pch_state_w, bmc_state_w;

    pfr_rst_chan #(
        .MIN_ASSERT_CYCLES (MIN_ASSERT_CYCLES),
        .CNT_W             (CNT_W)
    ) u_pch_chan (
        .clk          (clk),
        .srst         (srst),
        .req_i        (clean_w[0]),
        .release_en_i (pch_release_en),
        .state_o      (pch_state_w),
        .rst_n_o      (rst_rsmrst_n),
        .req_drop_o   (pch_req_drop)
    );

    pfr_rst_chan #(
        .MIN_ASSERT_CYCLES (MIN_ASSERT_CYCLES),
        .CNT_W             (CNT_W)
    ) u_bmc_chan (
        .clk          (clk),
        .srst         (srst),
        .req_i        (clean_w[1]),
        .release_en_i (bmc_release_en),
        .state_o      (bmc_state_w),
        .rst_n_o      (rst_srst_bmc_n),
        .req_drop_o   (bmc_req_drop)
    );

    logic pch_run_w, pch_pwrok_q, sys_pwrok_q;

    assign pch_run_w = (pch_state_w == RUN);

    // SYS PWROK chains off the registered PCH PWROK so it can never lead it,
    // and also drops directly with the PCH channel so both fall together.
    always_ff @(posedge clk) begin
        if (srst) begin
            pch_pwrok_q <= 1'b0;
            sys_pwrok_q <= 1'b0;
        end else begin
            pch_pwrok_q <= clean_w[2] & pch_run_w;
            sys_pwrok_q <= clean_w[3] & pch_pwrok_q & pch_run_w;
        end
    end

    assign pch_pwrok_out = pch_pwrok_q;
    assign sys_pwrok_out = sys_pwrok_q;
    assign status        = {pch_state_w, bmc_state_w};

endmodule : pfr_main_rst_gate

`default_nettype wire

// File: tb/tb_pfr_main_rst_gate.sv
// ============================================================================
// Module      : tb_pfr_main_rst_gate
// Description : Directed plus randomized bench against a timing-rule model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pfr_main_rst_gate;

    localparam int MIN  = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       rsmrst_req_n = 1'b0, srst_bmc_req_n = 1'b0;
    logic       pch_pwrok_in = 1'b0, sys_pwrok_in = 1'b0;
    logic       pch_release_en = 1'b0, bmc_release_en = 1'b0;
    logic       rst_rsmrst_n, rst_srst_bmc_n, pch_pwrok_out, sys_pwrok_out;
    logic       pch_req_drop, bmc_req_drop;
    logic [3:0] status;

    pfr_main_rst_gate #(
        .MIN_ASSERT_CYCLES (MIN),
        .CNT_W             (16),
        .SYNC_STAGES       (SYNC)
    ) dut (
        .clk            (clk),
        .srst           (srst),
        .rsmrst_req_n   (rsmrst_req_n),
        .srst_bmc_req_n (srst_bmc_req_n),
        .pch_pwrok_in   (pch_pwrok_in),
        .sys_pwrok_in   (sys_pwrok_in),
        .pch_release_en (pch_release_en),
        .bmc_release_en (bmc_release_en),
        .rst_rsmrst_n   (rst_rsmrst_n),
        .rst_srst_bmc_n (rst_srst_bmc_n),
        .pch_pwrok_out  (pch_pwrok_out),
        .sys_pwrok_out  (sys_pwrok_out),
        .pch_req_drop   (pch_req_drop),
        .bmc_req_drop   (bmc_req_drop),
        .status         (status)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a channel is running or not; when not running, it remembers the
    // edge at which reset was (re)asserted and may release once enough edges
    // have elapsed. Async inputs are seen SYNC edges after being sampled.
    int         cyc = 0;
    bit         m_run  [2];
    int         m_e    [2];
    bit         m_drop [2];
    bit         m_pp, m_sp;
    logic [3:0] hist [$];

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [1:0] m_status(int c);
        if (m_run[c])                return 2'd2;
        else if (cyc - m_e[c] >= MIN + 1) return 2'd1;
        else                         return 2'd0;
    endfunction

    task automatic chan_upd(int c, bit req, bit rel);
        m_drop[c] = 1'b0;
        if (m_run[c]) begin
            if (!req) begin
                m_run[c] = 1'b0; m_drop[c] = 1'b1; m_e[c] = cyc;
            end else if (!rel) begin
                m_run[c] = 1'b0; m_e[c] = cyc;
            end
        end else if ((cyc - 1 - m_e[c] >= MIN + 1) && req && rel) begin
            m_run[c] = 1'b1;
        end
    endtask

    task automatic model_edge();
        logic [3:0] s;
        bit         prun, new_sp;
        cyc++;
        if (srst) begin
            for (int c = 0; c < 2; c++) begin
                m_run[c] = 1'b0; m_e[c] = cyc; m_drop[c] = 1'b0;
            end
            m_pp = 1'b0; m_sp = 1'b0;
            hist.delete();
            repeat (SYNC) hist.push_front(4'h0);
        end else begin
            s = hist[SYNC-1];
            hist.push_front({sys_pwrok_in, pch_pwrok_in, srst_bmc_req_n, rsmrst_req_n});
            void'(hist.pop_back());
            prun   = m_run[0];
            new_sp = s[3] & m_pp & prun;
            m_pp   = s[2] & prun;
            m_sp   = new_sp;
            chan_upd(0, s[0], pch_release_en);
            chan_upd(1, s[1], bmc_release_en);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rst_rsmrst_n",   {3'b0, rst_rsmrst_n},   {3'b0, m_run[0]});
        chk("rst_srst_bmc_n", {3'b0, rst_srst_bmc_n}, {3'b0, m_run[1]});
        chk("pch_pwrok_out",  {3'b0, pch_pwrok_out},  {3'b0, m_pp});
        chk("sys_pwrok_out",  {3'b0, sys_pwrok_out},  {3'b0, m_sp});
        chk("pch_req_drop",   {3'b0, pch_req_drop},   {3'b0, m_drop[0]});
        chk("bmc_req_drop",   {3'b0, bmc_req_drop},   {3'b0, m_drop[1]});
        chk("status",         status,                 {m_status(0), m_status(1)});
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    initial begin
        // Reset state.
        steps(3);
        chk("reset_status", status, 4'h0);
        chk("reset_rst", {2'b0, rst_rsmrst_n, rst_srst_bmc_n}, 4'h0);

        // Release: request edge well after the minimum count.
        srst = 1'b0; pch_release_en = 1'b1; bmc_release_en = 1'b1;
        srst_bmc_req_n = 1'b1;
        steps(19);
        rsmrst_req_n = 1'b1;
        step(); chk("lat_rsmrst_1", {3'b0, rst_rsmrst_n}, 4'h0);
        step(); chk("lat_rsmrst_2", {3'b0, rst_rsmrst_n}, 4'h0);
        step(); chk("lat_rsmrst_3", {3'b0, rst_rsmrst_n}, 4'h1);

        // Early request: BMC request high since srst release.
        chk("early_bmc_run", {3'b0, rst_srst_bmc_n}, 4'h1);
        steps(5);

        // Request drop on BMC, then immediate re-raise.
        srst_bmc_req_n = 1'b0;
        step(); chk("drop_wait_1", {3'b0, bmc_req_drop}, 4'h0);
        step(); chk("drop_wait_2", {3'b0, bmc_req_drop}, 4'h0);
        step(); chk("drop_pulse",  {2'b0, bmc_req_drop, rst_srst_bmc_n}, 4'h2);
        srst_bmc_req_n = 1'b1;
        step(); chk("drop_once",   {3'b0, bmc_req_drop}, 4'h0);
        steps(14);

        // PWROK ordering: SYS first, PCH five cycles later.
        sys_pwrok_in = 1'b1;
        steps(5);
        pch_pwrok_in = 1'b1;
        steps(4);
        chk("pwrok_both", {2'b0, pch_pwrok_out, sys_pwrok_out}, 4'h3);

        // PFR hold on PCH.
        pch_release_en = 1'b0;
        step(); chk("hold_rst", {2'b0, rst_rsmrst_n, pch_req_drop}, 4'h0);
        chk("hold_pwrok_still", {3'b0, pch_pwrok_out}, 4'h1);
        step(); chk("hold_pwrok_fall", {2'b0, pch_pwrok_out, sys_pwrok_out}, 4'h0);
        pch_release_en = 1'b1;
        steps(16);

        // Request drop and hold reaching the FSM on the same edge.
        rsmrst_req_n = 1'b0;
        steps(2);
        pch_release_en = 1'b0;
        step(); chk("both_drop_pulse", {3'b0, pch_req_drop}, 4'h1);
        rsmrst_req_n = 1'b1; pch_release_en = 1'b1;
        steps(16);

        // srst in the middle of RUN.
        srst = 1'b1;
        step(); chk("srst_mid", {rst_rsmrst_n, rst_srst_bmc_n, pch_pwrok_out, sys_pwrok_out}, 4'h0);
        srst = 1'b0;
        steps(9);
        chk("srst_rerelease_min", {2'b0, rst_rsmrst_n, rst_srst_bmc_n}, 4'h0);
        steps(6);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39, 0) == 0) rsmrst_req_n   = ~rsmrst_req_n;
            if ($urandom_range(39, 0) == 0) srst_bmc_req_n = ~srst_bmc_req_n;
            if ($urandom_range(19, 0) == 0) pch_pwrok_in   = ~pch_pwrok_in;
            if ($urandom_range(19, 0) == 0) sys_pwrok_in   = ~sys_pwrok_in;
            if ($urandom_range(29, 0) == 0) pch_release_en = ~pch_release_en;
            if ($urandom_range(29, 0) == 0) bmc_release_en = ~bmc_release_en;
            srst = ($urandom_range(499, 0) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pfr_main_rst_gate

`default_nettype wire

// File: doc/pfr_main_rst_gate.md
Name: pfr_main_rst_gate

Overview:
- Sits on the PFR side, directly downstream of the main CPLD wrapper.
- Consumes the main CPLD's reset-release requests (RSMRST, BMC SRST) and its PCH/SYS PWROK outputs.
- Drives the real RST_RSMRST and RST_SRST_BMC resets, plus the gated PWROK signals.
- A reset is released only when two things hold: the main CPLD requests it, and the PFR recovery/T0 logic permits it. Any request drop or PFR hold re-asserts the reset, with a guaranteed minimum assertion time.

Parameters:
- MIN_ASSERT_CYCLES, 5000: minimum clk cycles a reset stays asserted once asserted (100 us at 50 MHz).
- CNT_W, 16: counter width; must satisfy 2^CNT_W > MIN_ASSERT_CYCLES.
- SYNC_STAGES, 2: synchronizer depth on all asynchronous inputs; legal range 2..3.

Ports:
- clk  in  1  50 MHz PFR clock
- srst  in  1  synchronous active-high reset
- rsmrst_req_n  in  1  async; main CPLD request to release PCH RSMRST (1 = release)
- srst_bmc_req_n  in  1  async; main CPLD request to release BMC SRST (1 = release)
- pch_pwrok_in  in  1  async; PWRGD_PCH_PWROK from main CPLD
- sys_pwrok_in  in  1  async; PWRGD_SYS_PWROK from main CPLD
- pch_release_en  in  1  sync; PFR permits PCH out of reset
- bmc_release_en  in  1  sync; PFR permits BMC out of reset
- rst_rsmrst_n  out  1  PCH RSMRST to board
- rst_srst_bmc_n  out  1  BMC SRST to board
- pch_pwrok_out  out  1  gated PCH PWROK
- sys_pwrok_out  out  1  gated SYS PWROK
- pch_req_drop  out  1  one-cycle pulse: PCH request fell while PCH channel in RUN
- bmc_req_drop  out  1  one-cycle pulse: BMC request fell while BMC channel in RUN
- status  out  4  {pch_state[1:0], bmc_state[1:0]}

Behaviour:
- Reset values (srst=1): rst_rsmrst_n=0, rst_srst_bmc_n=0, pch_pwrok_out=0, sys_pwrok_out=0, both drop pulses 0, both channels HELD, counters 0, synchronizer flops 0.
- srst mid-operation: same values on the next edge, regardless of state; the count restarts from 0 afterwards.
- The async inputs pass through SYNC_STAGES flops. pch_release_en and bmc_release_en are used directly.
- Two independent channels, PCH and BMC, with an identical FSM. Encoding: HELD=0, WAIT=1, RUN=2; code 3 is illegal and goes to HELD.
- HELD:
  - reset output 0; counter increments by 1 each cycle, saturating at MIN_ASSERT_CYCLES.
  - moves to WAIT when the counter equals MIN_ASSERT_CYCLES.
- WAIT:
  - reset output 0.
  - moves to RUN when req_sync=1 and release_en=1 in the same cycle.
- RUN:
  - reset output 1.
  - if req_sync=0: go to HELD, clear the counter, pulse req_drop for one cycle.
  - else if release_en=0: go to HELD, clear the counter, no pulse.
  - if both fall in the same cycle: go to HELD and do pulse (the request drop takes precedence).
- Reset output is registered from the state: high exactly in RUN.
- Latency: a request rising edge with release already permitted and the counter already satisfied gives an output rise SYNC_STAGES+1 cycles later (3 cycles at default).
- A request pulse shorter than the sync depth may be missed. This is acceptable and is not a requirement.
- pch_pwrok_out is a registered pch_pwrok_sync AND (PCH channel in RUN).
- sys_pwrok_out is a registered sys_pwrok_sync AND pch_pwrok_out(previous cycle). SYS PWROK therefore never rises before PCH PWROK, and drops in the same cycle as or after PCH PWROK.
- When the PCH channel leaves RUN, both PWROK outputs fall on the next edge.

Optional Feature:
- Macro: PFR_RST_REQ_GLITCH_FILTER_EN.
- When defined, each synchronized request and PWROK input passes through a 4-cycle stability filter. The filtered value changes only after 4 consecutive equal samples. This adds 4 cycles to every input-to-output latency above.
- When undefined, the synchronizer output is used directly.

Decomposition:
- Package pfr_rst_gate_pkg holds:
  - typedef enum logic [1:0] rst_chan_state_e {HELD, WAIT, RUN};
  - the filter-length constant RST_FILT_LEN = 4.
- Sub-module pfr_rst_chan contains the per-channel FSM, counter and drop pulse. It is instantiated twice. The synchronizers, filters and PWROK gating live in the top.

Test Plan (MIN_ASSERT_CYCLES=8, SYNC_STAGES=2, filter off):
- Release: srst low, both release_en=1, rsmrst_req_n rises at cycle 20 → rst_rsmrst_n=1 at cycle 23. The minimum count is met by cycle 9, so the request edge governs.
- Early request: request already high at srst release → output rises at the cycle the counter reaches 8, plus 1 (not earlier). Status reads HELD, then WAIT, then RUN.
- Request drop: in RUN, srst_bmc_req_n falls at cycle 100 → bmc_req_drop single pulse and rst_srst_bmc_n=0 at cycle 103. Re-raising the request at 104 keeps the output low until ≥8 HELD cycles have elapsed.
- PFR hold: in RUN, pch_release_en=0 → output 0 on the next edge, no drop pulse, pch_pwrok_out and sys_pwrok_out fall on the following edge. Then drive simultaneous req drop and release_en=0 → pulse asserted.
- PWROK ordering: PCH in RUN, sys_pwrok_in rises 5 cycles before pch_pwrok_in → sys_pwrok_out rises exactly 1 cycle after pch_pwrok_out.
- srst mid-RUN: all outputs 0 next edge; counter restarts; output re-release takes ≥9 cycles. With PFR_RST_REQ_GLITCH_FILTER_EN defined, a 3-cycle request glitch produces no output change.
